// File: rtl/fighter_fsm_gen.sv
// Per-player fighter controller: movement with screen/opponent clamps, timed attacks, hit/block stun.
// Optional health/KO tracking is compiled in with `define FIGHTER_HEALTH_EN.
module fighter_fsm_gen #(
  parameter bit          FACING_RIGHT = 1'b1,
  parameter int unsigned START_X      = 10,
  parameter int unsigned MIN_X        = 0,
  parameter int unsigned MAX_X        = 576,
  parameter int unsigned SPRITE_W     = 64,
  parameter int unsigned FWD_STEP     = 3,
  parameter int unsigned BWD_STEP     = 2,
  parameter int unsigned N_SU         = 4,
  parameter int unsigned N_ACT        = 1,
  parameter int unsigned N_REC        = 15,
  parameter int unsigned D_SU         = 3,
  parameter int unsigned D_ACT        = 2,
  parameter int unsigned D_REC        = 14,
  parameter int unsigned HITSTUN_F    = 16,
  parameter int unsigned BLOCKSTUN_F  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       play_active,
  input  logic [9:0] x_pos_opponent,
  input  logic       hit_in,
  output logic [9:0] x_pos,
  output logic [3:0] state,
  output logic       attack_kind,
  output logic [4:0] phase_frame,
  output logic       hitbox_active,
  output logic       blocking,
  output logic [2:0] health,
  output logic       ko
);

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StMoveFwd   = 4'd1,
    StMoveBwd   = 4'd2,
    StAtkSu     = 4'd3,
    StAtkAct    = 4'd4,
    StAtkRec    = 4'd5,
    StHitstun   = 4'd6,
    StBlockstun = 4'd7
  } state_e;

  localparam logic [10:0] MinX    = 11'(MIN_X);
  localparam logic [10:0] MaxX    = 11'(MAX_X);
  localparam logic [10:0] SpriteW = 11'(SPRITE_W);

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic        kind_q, kind_d;
  logic [4:0]  phase_q, phase_d;
  logic        hitbox_q, hitbox_d;
  logic        blocking_q, blocking_d;
  logic        fwd, bwd, mv_fwd, mv_bwd, dir_up, halted;
  logic [4:0]  phase_last;
  state_e      timed_next;
  logic [10:0] x_ext, step, x_step, x_scr, opp_lim, x_opp, x_fin;

`ifdef FIGHTER_HEALTH_EN
  logic [2:0] health_q, health_d;
  logic       ko_q, ko_d;
  assign halted = ko_q;
`else
  assign halted = 1'b0;
`endif

  // Player 2 faces left, so its forward button is btn_left.
  assign fwd    = FACING_RIGHT ? btn_right : btn_left;
  assign bwd    = FACING_RIGHT ? btn_left : btn_right;
  assign mv_fwd = fwd & ~bwd;
  assign mv_bwd = bwd & ~fwd;

  always_comb begin
    phase_last = 5'd0;
    timed_next = StIdle;
    unique case (state_q)
      StAtkSu: begin
        phase_last = kind_q ? 5'(D_SU - 1) : 5'(N_SU - 1);
        timed_next = StAtkAct;
      end
      StAtkAct: begin
        phase_last = kind_q ? 5'(D_ACT - 1) : 5'(N_ACT - 1);
        timed_next = StAtkRec;
      end
      StAtkRec:    phase_last = kind_q ? 5'(D_REC - 1) : 5'(N_REC - 1);
      StHitstun:   phase_last = 5'(HITSTUN_F - 1);
      StBlockstun: phase_last = 5'(BLOCKSTUN_F - 1);
      default:     phase_last = 5'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    kind_d  = kind_q;
`ifdef FIGHTER_HEALTH_EN
    health_d = health_q;
`endif
    if (frame_tick) begin
      if (halted || !play_active) begin
        state_d = StIdle;
        phase_d = 5'd0;
      end else if (hit_in) begin
        state_d = (state_q == StMoveBwd || state_q == StBlockstun) ? StBlockstun : StHitstun;
        phase_d = 5'd0;
`ifdef FIGHTER_HEALTH_EN
        if (state_d == StHitstun && health_q != 3'd0) health_d = health_q - 3'd1;
`endif
      end else begin
        unique case (state_q)
          StIdle, StMoveFwd, StMoveBwd: begin
            phase_d = 5'd0;
            if (btn_attack) begin
              state_d = StAtkSu;
              kind_d  = (state_q != StIdle);
            end else if (mv_fwd) begin
              state_d = StMoveFwd;
            end else if (mv_bwd) begin
              state_d = StMoveBwd;
            end else begin
              state_d = StIdle;
            end
          end
          default: begin
            if (phase_q == phase_last) begin
              state_d = timed_next;
              phase_d = 5'd0;
            end else begin
              phase_d = phase_q + 5'd1;
            end
          end
        endcase
      end
    end
  end

  // Step, screen clamp, opponent clamp, then screen clamp again so the screen wins conflicts.
  always_comb begin
    x_ext  = {1'b0, x_q};
    step   = (state_d == StMoveFwd) ? 11'(FWD_STEP) : 11'(BWD_STEP);
    dir_up = ((state_d == StMoveFwd) == FACING_RIGHT);
    if (dir_up)              x_step = x_ext + step;
    else if (x_ext < step)   x_step = MinX;
    else                     x_step = x_ext - step;
    x_scr = (x_step < MinX) ? MinX : ((x_step > MaxX) ? MaxX : x_step);
    if (FACING_RIGHT) begin
      opp_lim = ({1'b0, x_pos_opponent} < SpriteW) ? MinX : {1'b0, x_pos_opponent} - SpriteW;
      x_opp   = (x_scr > opp_lim) ? opp_lim : x_scr;
    end else begin
      opp_lim = {1'b0, x_pos_opponent} + SpriteW;
      x_opp   = (x_scr < opp_lim) ? opp_lim : x_scr;
    end
    x_fin = (x_opp < MinX) ? MinX : ((x_opp > MaxX) ? MaxX : x_opp);
    x_d   = (state_d == StMoveFwd || state_d == StMoveBwd) ? x_fin[9:0] : x_q;
    hitbox_d   = (state_d == StAtkAct);
    blocking_d = (state_d == StMoveBwd || state_d == StBlockstun);
`ifdef FIGHTER_HEALTH_EN
    ko_d = (health_d == 3'd0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= 10'(START_X);
      kind_q     <= 1'b0;
      phase_q    <= 5'd0;
      hitbox_q   <= 1'b0;
      blocking_q <= 1'b0;
`ifdef FIGHTER_HEALTH_EN
      health_q   <= 3'd3;
      ko_q       <= 1'b0;
`endif
    end else if (frame_tick) begin
      state_q    <= state_d;
      x_q        <= x_d;
      kind_q     <= kind_d;
      phase_q    <= phase_d;
      hitbox_q   <= hitbox_d;
      blocking_q <= blocking_d;
`ifdef FIGHTER_HEALTH_EN
      health_q   <= health_d;
      ko_q       <= ko_d;
`endif
    end
  end

  assign x_pos         = x_q;
  assign state         = state_q;
  assign attack_kind   = kind_q;
  assign phase_frame   = phase_q;
  assign hitbox_active = hitbox_q;
  assign blocking      = blocking_q;
`ifdef FIGHTER_HEALTH_EN
  assign health = health_q;
  assign ko     = ko_q;
`else
  assign health = 3'd3;
  assign ko     = 1'b0;
`endif

endmodule

// File: tb/tb_fighter_fsm_gen.sv
// Scoreboard bench for fighter_fsm_gen: player-1, player-2 (facing left) and a near-left-edge instance.
module tb_fighter_fsm_gen;

`ifdef FIGHTER_HEALTH_EN
  localparam bit HealthEn = 1'b1;
`else
  localparam bit HealthEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [9:0] x;
    logic       kind;
    logic [4:0] ph;
    logic       hb;
    logic       blk;
    logic [2:0] hp;
    logic       ko;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic play_active = 1'b1;
  logic [2:0] bl, br, ba, hit;
  logic [9:0] opp [3];
  logic [9:0] xo [3];
  logic [3:0] sto [3];
  logic [4:0] pho [3];
  logic [2:0] hpo [3];
  logic [2:0] ko_o, hb_o, blk_o, kind_o;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [2:0] hp_model = 3'd3;

  always #5 clk = ~clk;

  fighter_fsm_gen #(.FACING_RIGHT(1'b1), .START_X(10)) u_p1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(bl[0]), .btn_right(br[0]),
    .btn_attack(ba[0]), .play_active(play_active), .x_pos_opponent(opp[0]), .hit_in(hit[0]),
    .x_pos(xo[0]), .state(sto[0]), .attack_kind(kind_o[0]), .phase_frame(pho[0]),
    .hitbox_active(hb_o[0]), .blocking(blk_o[0]), .health(hpo[0]), .ko(ko_o[0])
  );

  fighter_fsm_gen #(.FACING_RIGHT(1'b0), .START_X(170)) u_p2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(bl[1]), .btn_right(br[1]),
    .btn_attack(ba[1]), .play_active(play_active), .x_pos_opponent(opp[1]), .hit_in(hit[1]),
    .x_pos(xo[1]), .state(sto[1]), .attack_kind(kind_o[1]), .phase_frame(pho[1]),
    .hitbox_active(hb_o[1]), .blocking(blk_o[1]), .health(hpo[1]), .ko(ko_o[1])
  );

  fighter_fsm_gen #(.FACING_RIGHT(1'b1), .START_X(1)) u_edge (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(bl[2]), .btn_right(br[2]),
    .btn_attack(ba[2]), .play_active(play_active), .x_pos_opponent(opp[2]), .hit_in(hit[2]),
    .x_pos(xo[2]), .state(sto[2]), .attack_kind(kind_o[2]), .phase_frame(pho[2]),
    .hitbox_active(hb_o[2]), .blocking(blk_o[2]), .health(hpo[2]), .ko(ko_o[2])
  );

  function automatic exp_t obs(int k);
    return '{st: sto[k], x: xo[k], kind: kind_o[k], ph: pho[k], hb: hb_o[k], blk: blk_o[k],
             hp: hpo[k], ko: ko_o[k]};
  endfunction

  function automatic string fmt(exp_t v);
    return $sformatf("st=%0d x=%0d kind=%0d ph=%0d hb=%0d blk=%0d hp=%0d ko=%0d",
                     v.st, v.x, v.kind, v.ph, v.hb, v.blk, v.hp, v.ko);
  endfunction

  function automatic void push(int st, int x, bit kind, int ph, bit hb, bit blk, int hp, bit ko);
    sb.push_back('{st: 4'(st), x: 10'(x), kind: kind, ph: 5'(ph), hb: hb, blk: blk,
                   hp: 3'(hp), ko: ko});
  endfunction

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, o;
    push(0, 10, 0, 0, 0, 0, 3, 0);
    push(0, 170, 0, 0, 0, 0, 3, 0);
    push(0, 1, 0, 0, 0, 0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      o = obs(k);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_reset inst%0d: got %s, want %s", k, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_move_fwd();
    exp_t e, o;
    opp[0] = 10'd400;
    for (int i = 1; i <= 10; i++) push(1, 10 + 3 * i, 0, 0, 0, 0, 3, 0);
    push(0, 40, 0, 0, 0, 0, 3, 0);
    for (int i = 1; i <= 11; i++) begin
      br[0] = (i <= 10);
      tick();
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_move_fwd tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_neutral_attack();
    exp_t e, o;
    for (int i = 1; i <= 4; i++) push(3, 40, 0, i - 1, 0, 0, 3, 0);
    push(4, 40, 0, 0, 1, 0, 3, 0);
    for (int i = 6; i <= 20; i++) push(5, 40, 0, i - 6, 0, 0, 3, 0);
    push(0, 40, 0, 0, 0, 0, 3, 0);
    for (int i = 1; i <= 21; i++) begin
      ba[0] = (i == 1);
      tick();
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_neutral_attack tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_dir_attack();
    exp_t e, o;
    push(1, 43, 0, 0, 0, 0, 3, 0);
    for (int i = 1; i <= 3; i++) push(3, 43, 1, i - 1, 0, 0, 3, 0);
    for (int i = 4; i <= 5; i++) push(4, 43, 1, i - 4, 1, 0, 3, 0);
    for (int i = 6; i <= 19; i++) push(5, 43, 1, i - 6, 0, 0, 3, 0);
    push(0, 43, 1, 0, 0, 0, 3, 0);
    for (int i = 0; i <= 20; i++) begin
      br[0] = (i <= 1);
      ba[0] = (i == 1);
      tick();
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_dir_attack tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_clamp_opponent_left();
    exp_t e, o;
    opp[1] = 10'd100;
    push(1, 167, 0, 0, 0, 0, 3, 0);
    push(1, 164, 0, 0, 0, 0, 3, 0);
    push(1, 164, 0, 0, 0, 0, 3, 0);
    push(2, 166, 0, 0, 0, 1, 3, 0);
    push(0, 166, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 5; i++) begin
      bl[1] = (i < 3);
      br[1] = (i == 3);
      tick();
      e = sb.pop_front();
      o = obs(1);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_clamp_opponent_left tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_clamp_screen_left();
    exp_t e, o;
    opp[2] = 10'd400;
    push(2, 0, 0, 0, 0, 1, 3, 0);
    push(2, 0, 0, 0, 0, 1, 3, 0);
    push(1, 3, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      bl[2] = (i < 2);
      br[2] = (i == 2);
      tick();
      e = sb.pop_front();
      o = obs(2);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_clamp_screen_left tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
    br[2] = 1'b0;
  endtask

  task automatic test_hitstun();
    exp_t e, o;
    for (int i = 1; i <= 4; i++) push(3, 43, 0, i - 1, 0, 0, 3, 0);
    push(4, 43, 0, 0, 1, 0, 3, 0);
    if (HealthEn) hp_model = hp_model - 3'd1;
    for (int i = 6; i <= 21; i++) push(6, 43, 0, i - 6, 0, 0, hp_model, 0);
    push(0, 43, 0, 0, 0, 0, hp_model, 0);
    for (int i = 1; i <= 22; i++) begin
      ba[0]  = (i == 1);
      hit[0] = (i == 6);
      tick();
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_hitstun tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_blockstun();
    exp_t e, o;
    push(2, 41, 0, 0, 0, 1, hp_model, 0);
    for (int i = 1; i <= 12; i++) push(7, 41, 0, i - 1, 0, 1, hp_model, 0);
    push(0, 41, 0, 0, 0, 0, hp_model, 0);
    for (int i = 0; i <= 13; i++) begin
      bl[0]  = (i <= 1);
      hit[0] = (i == 1);
      tick();
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_blockstun tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_no_tick_and_inactive();
    exp_t e, o;
    push(0, 41, 0, 0, 0, 0, hp_model, 0);
    push(0, 41, 0, 0, 0, 0, hp_model, 0);
    br[0] = 1'b1; ba[0] = 1'b1; hit[0] = 1'b1;
    repeat (100) @(negedge clk);
    e = sb.pop_front();
    o = obs(0);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL test_no_tick: got %s, want %s", fmt(o), fmt(e));
    end
    play_active = 1'b0;
    tick();
    e = sb.pop_front();
    o = obs(0);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL test_play_inactive: got %s, want %s", fmt(o), fmt(e));
    end
    play_active = 1'b1; br[0] = 1'b0; ba[0] = 1'b0; hit[0] = 1'b0;
  endtask

  task automatic test_reset_mid_rec();
    exp_t e, o;
    for (int i = 1; i <= 4; i++) push(3, 41, 0, i - 1, 0, 0, hp_model, 0);
    push(4, 41, 0, 0, 1, 0, hp_model, 0);
    for (int i = 6; i <= 8; i++) push(5, 41, 0, i - 6, 0, 0, hp_model, 0);
    push(0, 10, 0, 0, 0, 0, 3, 0);
    for (int i = 1; i <= 8; i++) begin
      ba[0] = (i == 1);
      tick();
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_reset_mid_rec tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
    @(negedge clk) reset = 1'b1;
    #1;
    hp_model = 3'd3;
    e = sb.pop_front();
    o = obs(0);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL test_reset_mid_rec async: got %s, want %s", fmt(o), fmt(e));
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_health();
    exp_t e, o;
    for (int i = 1; i <= 3; i++) begin
      if (HealthEn) hp_model = hp_model - 3'd1;
      push(6, 10, 0, 0, 0, 0, hp_model, HealthEn && hp_model == 3'd0);
    end
    if (HealthEn) push(0, 10, 0, 0, 0, 0, 0, 1);
    else          push(6, 10, 0, 1, 0, 0, 3, 0);
    for (int i = 1; i <= 4; i++) begin
      hit[0] = (i <= 3);
      br[0]  = (i == 4);
      tick();
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL test_health tick%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
    br[0] = 1'b0; hit[0] = 1'b0;
  endtask

  initial begin
    bl = '0; br = '0; ba = '0; hit = '0;
    opp[0] = 10'd400; opp[1] = 10'd0; opp[2] = 10'd400;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_move_fwd();
    test_neutral_attack();
    test_dir_attack();
    test_clamp_opponent_left();
    test_clamp_screen_left();
    test_hitstun();
    test_blockstun();
    test_no_tick_and_inactive();
    test_reset_mid_rec();
    test_health();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fighter_fsm_gen.md
Name: fighter_fsm_gen

Overview:
Parametrised second-generation per-player fighter controller. Advances once per 60 Hz frame_tick on the fast system clock. Handles mirrored facing for either player, generic movement and attack timing, and adds hitstun/blockstun reaction to opponent hits. Two instances, one per player, sit between the input synchroniser and the sprite/renderer and hit-detection logic.

Parameters:
FACING_RIGHT, 1, 1 = player 1 (forward = btn_right); 0 = player 2 (forward = btn_left)
START_X, 10, x_pos after reset
MIN_X, 0, left screen clamp
MAX_X, 576, right screen clamp (640 − sprite width)
SPRITE_W, 64, minimum separation from opponent x_pos
FWD_STEP, 3, px per frame moving forward
BWD_STEP, 2, px per frame moving backward
N_SU / N_ACT / N_REC, 4 / 1 / 15, neutral attack startup/active/recovery frames (each ≥1, ≤31)
D_SU / D_ACT / D_REC, 3 / 2 / 14, directional attack phase frames (each ≥1, ≤31)
HITSTUN_F, 16, hitstun frames
BLOCKSTUN_F, 12, blockstun frames

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
frame_tick  in  1  one-clk pulse per frame; all state updates only on clk edges where frame_tick=1
btn_left  in  1  synchronised button
btn_right  in  1  synchronised button
btn_attack  in  1  synchronised button
play_active  in  1  gameplay enabled
x_pos_opponent  in  10  opponent sprite left X
hit_in  in  1  opponent hitbox overlapped this sprite; sampled on frame_tick
x_pos  out  10  sprite left X
state  out  4  current state encoding
attack_kind  out  1  0 = neutral, 1 = directional; valid in ATK_* states
phase_frame  out  5  frame index within current timed phase, 0-based
hitbox_active  out  1  1 only in ATK_ACT
blocking  out  1  1 in MOVE_BWD and BLOCKSTUN
health  out  3  remaining health
ko  out  1  health reached 0

Behaviour:
- Reset: state=IDLE, x_pos=START_X, attack_kind=0, phase_frame=0, hitbox_active=0, blocking=0, health=3, ko=0. Reset can interrupt any state, including mid-attack.
- All outputs are registered. Outputs are unchanged on clocks with frame_tick=0.
- State encoding: IDLE=0, MOVE_FWD=1, MOVE_BWD=2, ATK_SU=3, ATK_ACT=4, ATK_REC=5, HITSTUN=6, BLOCKSTUN=7.
- fwd/bwd = btn_right/btn_left when FACING_RIGHT=1, swapped when 0. fwd and bwd together count as neither.
- Transition priority per tick:
  1. play_active=0: go to IDLE, phase_frame=0, x held.
  2. hit_in=1: MOVE_BWD or BLOCKSTUN goes to BLOCKSTUN; every other state goes to HITSTUN. Attacks are cancelled. phase_frame restarts at 0.
  3. Attack press: btn_attack in IDLE goes to ATK_SU with kind 0; btn_attack in MOVE_FWD/MOVE_BWD goes to ATK_SU with kind 1.
  4. Movement: from IDLE/MOVE, fwd goes to MOVE_FWD, bwd goes to MOVE_BWD, otherwise IDLE.
- Timed phases: phase_frame increments each tick. When phase_frame == LEN−1, advance and reset phase_frame to 0. LEN comes from attack_kind (N_* or D_*) or the stun parameter.
  - ATK_SU → ATK_ACT → ATK_REC → IDLE.
  - HITSTUN/BLOCKSTUN → IDLE.
  - Button presses during timed phases are ignored; there is no buffering.
- Movement is applied on the tick the state is MOVE_*. Facing right: forward = +FWD_STEP, backward = −BWD_STEP. Facing left: signs negated.
- Clamps, in order:
  - Screen: MIN_X ≤ x ≤ MAX_X.
  - Facing right: x ≤ x_pos_opponent − SPRITE_W.
  - Facing left: x ≥ x_pos_opponent + SPRITE_W.
  - Use 11-bit intermediate arithmetic; subtraction underflow saturates to MIN_X.
  - If the opponent constraint conflicts with the screen constraint, the screen clamp wins.
- x_pos is never modified outside MOVE_* states.

Optional Feature:
- Macro: FIGHTER_HEALTH_EN.
- Defined: each entry into HITSTUN decrements health, saturating at 0. Re-entry while already in HITSTUN also decrements. ko=1 when health==0. While ko=1 the block is forced to IDLE and all inputs are ignored until reset.
- Undefined: health is constant 3, ko is constant 0, no decrement logic.

Test Plan:
- Reset, then 10 ticks with btn_right, FACING_RIGHT=1, opponent at 400 → x_pos=40, state=MOVE_FWD.
- btn_attack in IDLE, neutral → ATK_SU 4 ticks, hitbox_active high for exactly 1 tick, ATK_REC 15 ticks, IDLE on the 21st tick.
- Hold btn_right, then press attack → attack_kind=1, ATK_ACT lasts 2 ticks, total 19 ticks before IDLE.
- FACING_RIGHT=0, hold btn_left with opponent at 100, start x=170 → x stops at 164. Same setup at x=1 going backward → x stops at 0 with no wrap.
- hit_in during ATK_ACT → HITSTUN, hitbox_active=0, IDLE after 16 ticks. hit_in while holding back → BLOCKSTUN for 12 ticks.
- frame_tick held low for 100 clks with buttons held → no output change. Assert reset mid-ATK_REC → all reset values. With FIGHTER_HEALTH_EN defined, 3 hits → ko=1.
